mod_counter_ctl: RTL

- Parametrised modulo counter for FIR control: coefficient, tap and sample index sequencing.
- Generalises the fixed-modulus up-counter:
  - modulus programmable at run time, up to MAX_COUNT
  - up and down counting, parallel load with range check
  - wrap or saturate mode, registered wrap event pulse
- Instanced by the FIR controller for tap, coefficient-address and pipeline-drain counts.

---
 rtl/counter_pkg.sv | 20 ++
 rtl/mod_counter_ctl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the FIR control counters.
//   cnt_width(n) : bits needed to index n states ($clog2), used for the count
//                  width (n = MAX_COUNT) and modulus width (n = MAX_COUNT+1).
//   cnt_dir_e    : step direction decoded from the inc/dec strobes.
// -----------------------------------------------------------------------------
package counter_pkg;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_UP   = 2'd1,
    CNT_DOWN = 2'd2
  } cnt_dir_e;

endpackage

// File: rtl/mod_counter_ctl.sv
// -----------------------------------------------------------------------------
// mod_counter_ctl
// Run-time programmable modulo counter used by the FIR controller for tap,
// coefficient-address and pipeline-drain sequencing.
//
// Ports
//   clk       in   clock
//   reset     in   asynchronous active-high reset
//   clear     in   sync: count <- 0, latch modulus
//   load      in   sync: count <- load_val (range checked), latch modulus
//   load_val  in   [CW] parallel load value
//   modulus   in   [MW] requested modulus, 1..MAX_COUNT (others -> MAX_COUNT)
//   inc/dec   in   step up / down (both high = hold)
//   sat_mode  in   0 = wrap at boundaries, 1 = saturate
//   count     out  [CW] current count
//   co        out  count == modulus-1 (combinational)
//   zero      out  count == 0 (combinational)
//   wrap      out  one-cycle pulse aligned with the wrapped count value
//   load_err  out  one-cycle pulse aligned with a clamped load
//
// MAX_COUNT must be >= 2.
// -----------------------------------------------------------------------------
module mod_counter_ctl
  import counter_pkg::*;
#(
  parameter  int MAX_COUNT = 64,
  localparam int CW        = cnt_width(MAX_COUNT),
  localparam int MW        = cnt_width(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic [MW-1:0] modulus,
  input  logic          inc,
  input  logic          dec,
  input  logic          sat_mode,
  output logic [CW-1:0] count,
  output logic          co,
  output logic          zero,
  output logic          wrap,
  output logic          load_err
);

  localparam logic [MW-1:0] MOD_MAX = MW'(MAX_COUNT);
  localparam logic [MW-1:0] MOD_ONE = MW'(1);

  logic [CW-1:0] count_q, count_d;
  logic [MW-1:0] mod_q,   mod_d;
  logic          wrap_q,  wrap_d;
  logic          lerr_q,  lerr_d;

  cnt_dir_e      dir;
  logic [MW-1:0] mod_sel;    // sanitised modulus request
  logic [MW-1:0] count_ext;  // count widened to modulus width for compares
  logic [MW-1:0] top_val;    // mod_q - 1, at modulus width
  logic          at_top;
  logic          at_zero;

  // Illegal requests (0 or above MAX_COUNT) fall back to the full range so a
  // stray modulus never produces a zero-length loop.
  assign mod_sel = ((modulus == '0) || (modulus > MOD_MAX)) ? MOD_MAX : modulus;

  // Compares are done at MW bits; at CW bits a power-of-two MAX_COUNT would
  // alias mod_q == MAX_COUNT onto zero.
  assign count_ext = MW'(count_q);
  assign top_val   = mod_q - MOD_ONE;
  assign at_top    = (count_ext == top_val);
  assign at_zero   = (count_q == '0);

  always_comb begin
    unique case ({inc, dec})
      2'b10:   dir = CNT_UP;
      2'b01:   dir = CNT_DOWN;
      default: dir = CNT_HOLD;
    endcase
  end

  // Next state: clear > load > single-step. Pulses default low so they last
  // exactly one cycle and can never overlap.
  always_comb begin
    count_d = count_q;
    mod_d   = mod_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (clear) begin
      mod_d   = mod_sel;
      count_d = '0;
    end else if (load) begin
      mod_d = mod_sel;
      if (MW'(load_val) < mod_sel) begin
        count_d = load_val;
      end else begin
        // Out-of-range load clamps to the top of the new range.
        count_d = CW'(mod_sel - MOD_ONE);
        lerr_d  = 1'b1;
      end
    end else begin
      unique case (dir)
        CNT_UP: begin
          if (!at_top) begin
            count_d = count_q + CW'(1);
          end else if (!sat_mode) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end
        CNT_DOWN: begin
          if (!at_zero) begin
            count_d = count_q - CW'(1);
          end else if (!sat_mode) begin
            count_d = CW'(top_val);
            wrap_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      mod_q   <= MOD_MAX;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_q   <= mod_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign count    = count_q;
  assign co       = at_top;
  assign zero     = at_zero;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;

endmodule
